// File: rtl/jt7759_seq_pkg.sv
// Shared constants and state encoding for the jt7759 phrase sequencer.
package jt7759_seq_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned STROBE_LEN = 2;
    localparam int unsigned TIMEOUT    = 255;
    localparam int unsigned TICK_W     = 8;
    localparam int unsigned STATE_W    = 5;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 5'b00001,
        ST_STROBE  = 5'b00010,
        ST_WAITBSY = 5'b00100,
        ST_PLAYING = 5'b01000,
        ST_GAP     = 5'b10000
    } state_t;

endpackage

// File: rtl/jt7759_seq_fifo.sv
// 4x8 phrase FIFO; a push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module jt7759_seq_fifo
    import jt7759_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] head_c,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              push_ok;
    logic              pop_ok;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head_c  = mem[rd_ptr];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_d;
            full    <= (count_d == CNT_W'(FIFO_DEPTH));
            empty   <= (count_d == CNT_W'(0));
        end
    end

endmodule

// File: rtl/jt7759_seq.sv
// Queues CPU phrase requests and strobes them one at a time into a jt7759 ADPCM chip.
// Optional replay of the last phrase is enabled by defining JT7759_SEQ_LOOP_EN.
module jt7759_seq
    import jt7759_seq_pkg::*;
#(
    parameter int unsigned GAP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen_ctl,
`ifdef JT7759_SEQ_LOOP_EN
    input  logic              loop,
`endif
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_stop,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              tout,
    input  logic              snd_busyn,
    output logic              snd_stn,
    output logic [DATA_W-1:0] snd_din,
    output logic              snd_rst
);

    localparam logic [TICK_W-1:0] STROBE_LAST  = TICK_W'(STROBE_LEN - 1);
    localparam logic [TICK_W-1:0] TIMEOUT_LAST = TICK_W'(TIMEOUT - 1);
    localparam logic [TICK_W-1:0] GAP_LAST     = TICK_W'(GAP - 1);

    state_t              state_q;
    state_t              state_d;
    logic [TICK_W-1:0]   cnt_q;
    logic [TICK_W-1:0]   cnt_d;
    logic                stn_d;
    logic [DATA_W-1:0]   din_d;
    logic                ovf_d;
    logic                tout_d;
    logic                pop_c;
    logic [DATA_W-1:0]   head_c;

    jt7759_seq_fifo u_fifo (
        .clk    (clk),
        .rst    (rst),
        .clr    (cpu_stop),
        .push   (cpu_wr && !cpu_stop),
        .din    (cpu_din),
        .pop    (pop_c),
        .head_c (head_c),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            snd_stn <= 1'b1;
            snd_din <= '0;
            snd_rst <= 1'b1;
            ovf     <= 1'b0;
            tout    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snd_stn <= stn_d;
            snd_din <= din_d;
            snd_rst <= cpu_stop;
            ovf     <= ovf_d;
            tout    <= tout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stn_d   = snd_stn;
        din_d   = snd_din;
        tout_d  = tout;
        pop_c   = 1'b0;

        if (cen_ctl) begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty && snd_busyn) begin
                        pop_c   = 1'b1;
                        din_d   = head_c;
                        stn_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (cnt_q == STROBE_LAST) begin
                        stn_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_WAITBSY;
                    end else begin
                        cnt_d = cnt_q + TICK_W'(1);
                    end
                end
                ST_WAITBSY: begin
                    if (!snd_busyn) begin
                        cnt_d   = '0;
                        state_d = ST_PLAYING;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        tout_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + TICK_W'(1);
                    end
                end
                ST_PLAYING: begin
                    if (snd_busyn) begin
                        cnt_d   = '0;
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    // GAP=0 still spends one tick here before returning to IDLE
                    if ((GAP == 0) || (cnt_q == GAP_LAST)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
`ifdef JT7759_SEQ_LOOP_EN
                        if (empty && loop) begin
                            stn_d   = 1'b0;
                            state_d = ST_STROBE;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q + TICK_W'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Abort wins over everything, independent of the control enable
        if (cpu_stop) begin
            pop_c   = 1'b0;
            cnt_d   = '0;
            stn_d   = 1'b1;
            state_d = ST_IDLE;
        end

        ovf_d = ovf | (cpu_wr & ~cpu_stop & full & ~pop_c);
    end

endmodule
